mips_controller: RTL and testbench
==================================

MIPS_CONTROLLER -- requirements
Module: mips_controller

Interface
REQ-001 Parameter FUNCT_WIDTH, default 6: width of the op and funct inputs.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 op  input  6  instruction opcode field, instr[31:26].
REQ-005 funct  input  6  R-type function field, instr[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 alucont  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 100 NAND, 101 NOR, 110 SUB, 111 SLT.
REQ-008 iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  multicycle datapath controls.
REQ-009 alusrcb  output  2  ALU B select: 00 B register, 01 constant 4, 10 signimm, 11 signimm<<2.
REQ-010 pcsrc  output  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 pcen  output  1  PC write enable.
REQ-012 immext  output  1  immediate extension: 0 sign, 1 zero.
REQ-013 illegal_op  output  1  one-cycle pulse on an unsupported opcode or funct.
REQ-014 state  output  4  current FSM state, for debug.

Function
REQ-015 The block SHALL be a Moore FSM; all outputs SHALL be decoded from the registered state only, except pcen.
REQ-016 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ORIEX 12, ORIWB 13.
REQ-017 Transitions SHALL be:
- FETCH -> DECODE.
- DECODE on op: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> RTYPEEX; beq (000100) -> BEQEX; addi (001000) -> ADDIEX; j (000010) -> JEX; any other op -> FETCH with illegal_op=1.
- MEMADR -> MEMRD for lw, MEMWR for sw.
- MEMRD -> MEMWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- RTYPEEX -> RTYPEWB; ADDIEX -> ADDIWB.
REQ-018 FETCH: iord=0, alusrca=0, alusrcb=01, alucont=010, pcsrc=00, irwrite=1, pcwrite=1.
REQ-019 DECODE: alusrca=0, alusrcb=11, alucont=010.
REQ-020 MEMADR and ADDIEX: alusrca=1, alusrcb=10, alucont=010.
REQ-021 Memory-access and write-back states:
- MEMRD: iord=1.
- MEMWR: iord=1, memwrite=1.
- MEMWB: regdst=0, memtoreg=1, regwrite=1.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1.
REQ-022 RTYPEEX: alusrca=1, alusrcb=00; alucont decoded from funct: 100000->010, 100010->110, 100100->000, 100101->001, 100111->101, 101010->111.
REQ-023 An unsupported funct in RTYPEEX SHALL pulse illegal_op and go to FETCH, skipping RTYPEWB.
REQ-024 RTYPEWB: regdst=1, memtoreg=0, regwrite=1.
REQ-025 BEQEX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01, branch=1.
REQ-026 JEX: pcsrc=10, pcwrite=1.
REQ-027 Every output not listed for a state SHALL be 0 in that state; alucont SHALL default to 010.
REQ-028 pcen SHALL equal pcwrite OR (branch AND zero), combinational from the current zero input.
REQ-029 Instruction latency SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-030 When reset_n=0 at a rising clk edge, state SHALL become FETCH.
REQ-031 Reset SHALL take effect from any state, including mid-instruction, and SHALL abandon that instruction.
REQ-032 During reset, all outputs SHALL follow the FETCH decode; illegal_op SHALL be 0.

Configuration
REQ-033 With CTRL_ORI_EN defined:
- DECODE with op=001101 SHALL go to ORIEX.
- ORIEX: alusrca=1, alusrcb=10, immext=1, alucont=001.
- ORIWB: regwrite=1, regdst=0, memtoreg=0.
- ORIWB -> FETCH.
REQ-034 Without CTRL_ORI_EN, op=001101 SHALL be illegal, states 12/13 SHALL be unreachable, and immext SHALL be constant 0.

Structure
REQ-035 A shared package mips_pkg SHALL hold:
- the state enum;
- opcode and funct constants;
- alucont codes (identical to the ALU encoding);
- alusrcb and pcsrc select codes.
REQ-036 The funct-to-alucont decode SHALL be a separate sub-module named alu_decoder, combinational.

Verification
REQ-037 reset_n=0 in state MEMRD, then released -> state=0 on the next cycle; irwrite=1 and pcen=1.
REQ-038 op=100011 -> states 0,1,2,3,4; memwrite never set; regwrite=1 only in state 4.
REQ-039 op=000000 with funct=101010 -> alucont=111 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-040 op=000100: zero=1 in BEQEX -> pcen=1, pcsrc=01; zero=0 -> pcen=0; both cases -> FETCH next.
REQ-041 op=111111 -> illegal_op=1 for exactly one cycle; state returns to 0 after DECODE.
REQ-042 op=001101 with CTRL_ORI_EN -> states 12 then 13, immext=1, alucont=001; without the macro -> illegal_op pulse.

Source files
------------

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS controller:
//   - state_t    : FSM state encoding (also exported on the debug state port)
//   - op_t       : instruction opcode field values (instr[31:26])
//   - funct_t    : R-type function field values (instr[5:0])
//   - alucont_t  : ALU operation codes, identical to the ALU's own encoding
//   - srcb_t     : ALU B operand select codes
//   - pcsrc_t    : next-PC select codes
//   - ctrl_t     : bundle of per-state datapath controls
// ---------------------------------------------------------------------------
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_ORIEX   = 4'd12,
    S_ORIWB   = 4'd13
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } op_t;

  typedef enum logic [5:0] {
    F_ADD = 6'b100000,
    F_SUB = 6'b100010,
    F_AND = 6'b100100,
    F_OR  = 6'b100101,
    F_NOR = 6'b100111,
    F_SLT = 6'b101010
  } funct_t;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_NAND = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alucont_t;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  // Plain logic fields so that both enum constants and the R-type decoder
  // result can be assigned without casts.
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucont;
    logic       pcwrite;
    logic       branch;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational R-type function-field decoder.
// Ports:
//   funct   in  [FUNCT_WIDTH-1:0]  instruction funct field
//   alucont out [2:0]              ALU operation for that funct (ADD if unknown)
//   valid   out                    1 when funct is a supported R-type operation
// ---------------------------------------------------------------------------
module alu_decoder
  import mips_pkg::*;
#(
  parameter int FUNCT_WIDTH = 6
) (
  input  logic [FUNCT_WIDTH-1:0] funct,
  output logic [2:0]             alucont,
  output logic                   valid
);

  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned infers a latch.
  always_comb begin
    alucont = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      F_ADD:   alucont = ALU_ADD;
      F_SUB:   alucont = ALU_SUB;
      F_AND:   alucont = ALU_AND;
      F_OR:    alucont = ALU_OR;
      F_NOR:   alucont = ALU_NOR;
      F_SLT:   alucont = ALU_SLT;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// ---------------------------------------------------------------------------
// mips_controller
// Moore-style control FSM for a multicycle MIPS datapath. Every output is a
// decode of the registered state, with two exceptions: pcen also looks at
// the live ALU zero flag, and in RTYPEEX alucont comes from the funct field.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   synchronous active-low reset (returns to FETCH)
//   op          in   [FUNCT_WIDTH-1:0] opcode, instr[31:26]
//   funct       in   [FUNCT_WIDTH-1:0] R-type function, instr[5:0]
//   zero        in   ALU zero flag
//   alucont     out  [2:0] ALU operation
//   iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca
//               out  datapath controls
//   alusrcb     out  [1:0] ALU B select
//   pcsrc       out  [1:0] next-PC select
//   pcen        out  PC write enable = pcwrite | (branch & zero)
//   immext      out  immediate extension (0 sign, 1 zero)
//   illegal_op  out  one-cycle pulse, visible in the FETCH cycle that
//                    follows a rejected opcode or funct
//   state       out  [3:0] current state code, for debug
//
// Build option: define CTRL_ORI_EN to add ori (ORIEX/ORIWB states and the
// zero-extended immediate). Without it ori is illegal and immext is 0.
// ---------------------------------------------------------------------------
module mips_controller
  import mips_pkg::*;
#(
  parameter int FUNCT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [FUNCT_WIDTH-1:0] op,
  input  logic [FUNCT_WIDTH-1:0] funct,
  input  logic                   zero,
  output logic [2:0]             alucont,
  output logic                   iord,
  output logic                   irwrite,
  output logic                   memwrite,
  output logic                   regdst,
  output logic                   memtoreg,
  output logic                   regwrite,
  output logic                   alusrca,
  output logic [1:0]             alusrcb,
  output logic [1:0]             pcsrc,
  output logic                   pcen,
  output logic                   immext,
  output logic                   illegal_op,
  output logic [3:0]             state
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl;
  logic [2:0] rtype_alucont;
  logic       funct_ok;
`ifdef CTRL_ORI_EN
  logic       immext_d;
`endif

  alu_decoder #(.FUNCT_WIDTH(FUNCT_WIDTH)) u_alu_decoder (
    .funct   (funct),
    .alucont (rtype_alucont),
    .valid   (funct_ok)
  );

  // The illegal flag is registered rather than decoded from op in DECODE so
  // that illegal_op stays a pure function of registered state; it is seen
  // during the FETCH cycle the FSM falls back to. Reset clears it, so an
  // instruction abandoned by reset never reports.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    ctrl         = '0;
    ctrl.alucont = ALU_ADD;
    state_d      = S_FETCH;
    illegal_d    = 1'b0;
`ifdef CTRL_ORI_EN
    immext_d     = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcsrc   = PC_ALU;
        state_d      = S_DECODE;
      end

      S_DECODE: begin
        // Branch target is computed here, ahead of knowing the opcode.
        ctrl.alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef CTRL_ORI_EN
          OP_ORI:       state_d = S_ORIEX;
`endif
          default:      illegal_d = 1'b1;
        endcase
      end

      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        // Only lw and sw reach this state.
        state_d      = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = S_MEMWB;
      end

      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end

      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end

      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.alucont = rtype_alucont;
        // An unknown funct never reaches write-back, so no register is
        // corrupted by an undefined ALU result.
        if (funct_ok) state_d   = S_RTYPEWB;
        else          illegal_d = 1'b1;
      end

      S_RTYPEWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end

      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REG;
        ctrl.alucont = ALU_SUB;
        ctrl.pcsrc   = PC_ALUOUT;
        ctrl.branch  = 1'b1;
      end

      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = S_ADDIWB;
      end

      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end

      S_JEX: begin
        ctrl.pcsrc   = PC_JUMP;
        ctrl.pcwrite = 1'b1;
      end

`ifdef CTRL_ORI_EN
      S_ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.alucont = ALU_OR;
        immext_d     = 1'b1;
        state_d      = S_ORIWB;
      end

      S_ORIWB: begin
        ctrl.regwrite = 1'b1;
      end
`endif

      default: begin
        // Unused codes fall back to FETCH with all controls idle.
      end
    endcase
  end

  assign alucont    = ctrl.alucont;
  assign iord       = ctrl.iord;
  assign irwrite    = ctrl.irwrite;
  assign memwrite   = ctrl.memwrite;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
  assign illegal_op = illegal_q;
  assign state      = state_q;
`ifdef CTRL_ORI_EN
  assign immext     = immext_d;
`else
  assign immext     = 1'b0;
`endif

endmodule

// File: tb/tb_mips_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_controller
// Directed self-checking bench for mips_controller. Each task starts and
// ends with the FSM in FETCH, inputs change 1 ns after a rising edge and
// outputs are observed at that same point.
// ---------------------------------------------------------------------------
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucont;
  logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen, immext, illegal_op;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  mips_controller #(.FUNCT_WIDTH(6)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alucont    (alucont),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .immext     (immext),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    op      = 6'b111111;
    funct   = 6'b000000;
    zero    = 1'b0;
    step();
    step();
    total++;
    if (state !== 4'd0) begin
      bad++; $display("FAIL reset_state: got=%0d want=0", state);
    end
    total++;
    if (illegal_op !== 1'b0) begin
      bad++; $display("FAIL reset_illegal: got=%b want=0", illegal_op);
    end
    // {iord,irwrite,memwrite,regdst,memtoreg,regwrite,alusrca,pcen,immext}
    total++;
    if ({iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, immext} !== 9'b010000010) begin
      bad++; $display("FAIL reset_ctrl: got=%b want=010000010",
                      {iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca, pcen, immext});
    end
    total++;
    if ({alusrcb, pcsrc, alucont} !== 7'b01_00_010) begin
      bad++; $display("FAIL reset_sel: got=%b want=0100010", {alusrcb, pcsrc, alucont});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    op = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (state !== exp_st[i]) begin
        bad++; $display("FAIL lw_state[%0d]: got=%0d want=%0d", i, state, exp_st[i]);
      end
      total++;
      if (memwrite !== 1'b0) begin
        bad++; $display("FAIL lw_memwrite[%0d]: got=%b want=0", i, memwrite);
      end
      total++;
      if (regwrite !== (i == 4)) begin
        bad++; $display("FAIL lw_regwrite[%0d]: got=%b want=%b", i, regwrite, (i == 4));
      end
      if (i == 2) begin
        total++;
        if ({alusrca, alusrcb, alucont} !== 6'b1_10_010) begin
          bad++; $display("FAIL lw_memadr: got=%b want=110010", {alusrca, alusrcb, alucont});
        end
      end
      if (i == 3) begin
        total++;
        if (iord !== 1'b1) begin
          bad++; $display("FAIL lw_iord: got=%b want=1", iord);
        end
      end
      if (i == 4) begin
        total++;
        if ({regdst, memtoreg} !== 2'b01) begin
          bad++; $display("FAIL lw_memwb: got=%b want=01", {regdst, memtoreg});
        end
      end
      if (i < 5) step();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    op = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (state !== exp_st[i]) begin
        bad++; $display("FAIL sw_state[%0d]: got=%0d want=%0d", i, state, exp_st[i]);
      end
      total++;
      if ({memwrite, iord, regwrite} !== ((i == 3) ? 3'b110 : 3'b000)) begin
        bad++; $display("FAIL sw_ctrl[%0d]: got=%b want=%b", i, {memwrite, iord, regwrite},
                        ((i == 3) ? 3'b110 : 3'b000));
      end
      if (i < 4) step();
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [2:0] alu [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b101,    3'b111};
    op = 6'b000000;
    for (int k = 0; k < 6; k++) begin
      funct = fn[k];
      step();
      step();
      total++;
      if (state !== 4'd6) begin
        bad++; $display("FAIL rtype_ex_state[%0d]: got=%0d want=6", k, state);
      end
      total++;
      if ({alucont, alusrca, alusrcb, regwrite} !== {alu[k], 1'b1, 2'b00, 1'b0}) begin
        bad++; $display("FAIL rtype_ex_ctrl[%0d]: got=%b want=%b", k,
                        {alucont, alusrca, alusrcb, regwrite}, {alu[k], 1'b1, 2'b00, 1'b0});
      end
      step();
      total++;
      if ({state, regdst, regwrite, memtoreg} !== {4'd7, 3'b110}) begin
        bad++; $display("FAIL rtype_wb[%0d]: got=%b want=%b", k,
                        {state, regdst, regwrite, memtoreg}, {4'd7, 3'b110});
      end
      step();
      total++;
      if ({state, illegal_op} !== {4'd0, 1'b0}) begin
        bad++; $display("FAIL rtype_done[%0d]: got=%b want=00000", k, {state, illegal_op});
      end
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      op   = 6'b000100;
      zero = 1'b1;
      step();
      total++;
      if ({state, pcen} !== {4'd1, 1'b0}) begin
        bad++; $display("FAIL beq_decode_pcen[z=%0d]: got=%b want=00010", z, {state, pcen});
      end
      zero = z[0];
      step();
      total++;
      if (state !== 4'd8) begin
        bad++; $display("FAIL beq_state[z=%0d]: got=%0d want=8", z, state);
      end
      total++;
      if ({pcen, pcsrc, alucont, alusrca, alusrcb} !== {z[0], 2'b01, 3'b110, 1'b1, 2'b00}) begin
        bad++; $display("FAIL beq_ctrl[z=%0d]: got=%b want=%b", z,
                        {pcen, pcsrc, alucont, alusrca, alusrcb}, {z[0], 2'b01, 3'b110, 1'b1, 2'b00});
      end
      // pcen follows zero within the same cycle.
      zero = ~z[0];
      #1;
      total++;
      if (pcen !== ~z[0]) begin
        bad++; $display("FAIL beq_pcen_comb[z=%0d]: got=%b want=%b", z, pcen, ~z[0]);
      end
      step();
      total++;
      if (state !== 4'd0) begin
        bad++; $display("FAIL beq_next[z=%0d]: got=%0d want=0", z, state);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_addi_j();
    op = 6'b001000;
    step();
    step();
    total++;
    if ({state, alusrca, alusrcb, alucont, regwrite} !== {4'd9, 1'b1, 2'b10, 3'b010, 1'b0}) begin
      bad++; $display("FAIL addi_ex: got=%b want=%b", {state, alusrca, alusrcb, alucont, regwrite},
                      {4'd9, 1'b1, 2'b10, 3'b010, 1'b0});
    end
    step();
    total++;
    if ({state, regwrite, regdst, memtoreg} !== {4'd10, 3'b100}) begin
      bad++; $display("FAIL addi_wb: got=%b want=%b", {state, regwrite, regdst, memtoreg}, {4'd10, 3'b100});
    end
    step();
    op = 6'b000010;
    step();
    step();
    total++;
    if ({state, pcsrc, pcen, irwrite} !== {4'd11, 2'b10, 1'b1, 1'b0}) begin
      bad++; $display("FAIL j_ex: got=%b want=%b", {state, pcsrc, pcen, irwrite}, {4'd11, 2'b10, 1'b1, 1'b0});
    end
    step();
    total++;
    if (state !== 4'd0) begin
      bad++; $display("FAIL j_next: got=%0d want=0", state);
    end
  endtask

  task automatic test_illegal_op();
    int pulses = 0;
    logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd0, 4'd1};
    logic       exp_il [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    op = 6'b111111;
    for (int i = 0; i < 4; i++) begin
      if (illegal_op === 1'b1) pulses++;
      total++;
      if ({state, illegal_op} !== {exp_st[i], exp_il[i]}) begin
        bad++; $display("FAIL illop[%0d]: got st=%0d il=%b want st=%0d il=%b", i,
                        state, illegal_op, exp_st[i], exp_il[i]);
      end
      if (i == 2) op = 6'b000010;
      if (i < 3) step();
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL illop_pulse_count: got=%0d want=1", pulses);
    end
    step();
    step();
  endtask

  task automatic test_illegal_funct();
    op    = 6'b000000;
    funct = 6'b111111;
    step();
    step();
    total++;
    if (state !== 4'd6) begin
      bad++; $display("FAIL illfn_ex: got=%0d want=6", state);
    end
    step();
    total++;
    if ({state, illegal_op, regwrite} !== {4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL illfn_skip_wb: got=%b want=000010", {state, illegal_op, regwrite});
    end
    op = 6'b000010;
    step();
    total++;
    if ({state, illegal_op} !== {4'd1, 1'b0}) begin
      bad++; $display("FAIL illfn_clear: got=%b want=00010", {state, illegal_op});
    end
    step();
    step();
  endtask

  task automatic test_ori();
    op = 6'b001101;
    step();
    step();
`ifdef CTRL_ORI_EN
    total++;
    if ({state, immext, alucont, alusrca, alusrcb} !== {4'd12, 1'b1, 3'b001, 1'b1, 2'b10}) begin
      bad++; $display("FAIL ori_ex: got=%b want=%b", {state, immext, alucont, alusrca, alusrcb},
                      {4'd12, 1'b1, 3'b001, 1'b1, 2'b10});
    end
    step();
    total++;
    if ({state, regwrite, regdst, memtoreg, immext} !== {4'd13, 4'b1000}) begin
      bad++; $display("FAIL ori_wb: got=%b want=%b", {state, regwrite, regdst, memtoreg, immext}, {4'd13, 4'b1000});
    end
    step();
    total++;
    if (state !== 4'd0) begin
      bad++; $display("FAIL ori_next: got=%0d want=0", state);
    end
`else
    total++;
    if ({state, illegal_op, immext} !== {4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ori_disabled: got=%b want=000010", {state, illegal_op, immext});
    end
    op = 6'b000010;
    step();
    step();
    step();
`endif
  endtask

  task automatic test_reset_mid();
    op = 6'b100011;
    step();
    step();
    step();
    total++;
    if (state !== 4'd3) begin
      bad++; $display("FAIL rstmid_reach: got=%0d want=3", state);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    total++;
    if ({state, irwrite, pcen, iord} !== {4'd0, 3'b110}) begin
      bad++; $display("FAIL rstmid_fetch: got=%b want=0000110", {state, irwrite, pcen, iord});
    end
    step();
    total++;
    if (state !== 4'd1) begin
      bad++; $display("FAIL rstmid_restart: got=%0d want=1", state);
    end
    // Reset at the DECODE edge of an illegal opcode must suppress the pulse.
    op      = 6'b111111;
    reset_n = 1'b0;
    step();
    total++;
    if ({state, illegal_op} !== {4'd0, 1'b0}) begin
      bad++; $display("FAIL rstdec_illegal: got=%b want=00000", {state, illegal_op});
    end
    step();
    total++;
    if ({state, illegal_op, irwrite} !== {4'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL rst_held: got=%b want=000001", {state, illegal_op, irwrite});
    end
    reset_n = 1'b1;
    op      = 6'b000010;
    step();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_st [15] = '{4'd0, 4'd1, 4'd11, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1,
                                4'd9, 4'd10, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [5:0] ops [4] = '{6'b000010, 6'b000100, 6'b001000, 6'b101011};
    int k = 0;
    zero = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (exp_st[i] == 4'd0 && k < 4) begin
        op = ops[k];
        k++;
      end
      total++;
      if (state !== exp_st[i]) begin
        bad++; $display("FAIL b2b_state[%0d]: got=%0d want=%0d", i, state, exp_st[i]);
      end
      if (i < 14) step();
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_addi_j();
    test_illegal_op();
    test_illegal_funct();
    test_ori();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
